// File: rtl/lcd_rgb_rx.sv
// LCD RGB565 receiver: samples DE/HSYNC/VSYNC/RGB, emits a qualified pixel
// stream with coordinates, measures frame geometry and tracks format lock.
//
// Ports:
//   PixelClk, nRST (async, active-low)
//   LCD_DE/HSYNC/VSYNC/R/G/B : parallel video input
//   pix_valid/pix_data/pix_x/pix_y/sof/eol : pixel stream (3-cycle latency)
//   meas_width/height/htotal/vtotal : geometry of last complete frame
//   locked, fmt_err : format lock state, loss-of-format pulse
module lcd_rgb_rx #(
  parameter bit          SYNC_POL    = 1'b1,
  parameter int unsigned LOCK_FRAMES = 3
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic        LCD_DE,
  input  logic        LCD_HSYNC,
  input  logic        LCD_VSYNC,
  input  logic [4:0]  LCD_R,
  input  logic [5:0]  LCD_G,
  input  logic [4:0]  LCD_B,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        sof,
  output logic        eol,
  output logic [15:0] meas_width,
  output logic [15:0] meas_height,
  output logic [15:0] meas_htotal,
  output logic [15:0] meas_vtotal,
  output logic        locked,
  output logic        fmt_err
);

  localparam logic [15:0] SAT     = 16'hFFFF;
  localparam logic [3:0]  LOCK_M1 = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } state_t;

  state_t      state, state_n;
  logic [3:0]  mcnt, mcnt_n;
  logic        err_q, err_n;

  logic        s1_de, s1_hs, s1_vs;
  logic        s2_de, s2_hs, s2_vs;
  logic [15:0] s1_rgb, s2_rgb;

  logic [15:0] x_cnt, y_cnt, hcnt, lcnt;
  logic [15:0] line_ht, w_ref;
  logic        hs_seen, ht_valid, w_lat;
  logic        frame_bad, prev_ok;
  logic [63:0] prev_meas;

  logic        hs_rise, vs_rise, de_fall;
  logic [15:0] wid, ht_cur, vt_cur;
  logic        h_err, w_err, bad_now, match;
  logic [63:0] meas_cur;

  // Syncs normalised to active-high on entry.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      s1_de  <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_rgb <= '0;
      s2_de  <= 1'b0;
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
      s2_rgb <= '0;
    end else begin
      s1_de  <= LCD_DE;
      s1_hs  <= LCD_HSYNC ^ ~SYNC_POL;
      s1_vs  <= LCD_VSYNC ^ ~SYNC_POL;
      s1_rgb <= {LCD_R, LCD_G, LCD_B};
      s2_de  <= s1_de;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_rgb <= s1_rgb;
    end
  end

  always_comb begin
    hs_rise = s1_hs & ~s2_hs;
    vs_rise = s1_vs & ~s2_vs;
    de_fall = s2_de & ~s1_de;
    wid     = (x_cnt == SAT) ? SAT : x_cnt + 16'd1;
    ht_cur  = hs_rise ? hcnt : line_ht;
    vt_cur  = (hs_rise && lcnt != SAT) ? lcnt + 16'd1 : lcnt;
    h_err   = hs_rise & ht_valid & (hcnt != line_ht);
    w_err   = de_fall & w_lat & (wid != w_ref);
    bad_now = frame_bad | h_err | w_err;
    meas_cur = {w_lat ? w_ref : 16'd0, y_cnt, ht_cur, vt_cur};
    match   = prev_ok & ~bad_now & (meas_cur == prev_meas);
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      hcnt     <= '0;
      lcnt     <= '0;
      line_ht  <= '0;
      hs_seen  <= 1'b0;
      ht_valid <= 1'b0;
      w_ref    <= '0;
      w_lat    <= 1'b0;
    end else begin
      if (de_fall)
        x_cnt <= '0;
      else if (s2_de && x_cnt != SAT)
        x_cnt <= x_cnt + 16'd1;

      if (vs_rise)
        y_cnt <= '0;
      else if (de_fall && y_cnt != SAT)
        y_cnt <= y_cnt + 16'd1;

      if (hs_rise)
        hcnt <= 16'd1;
      else if (hcnt != SAT)
        hcnt <= hcnt + 16'd1;

      if (vs_rise)
        lcnt <= '0;
      else if (hs_rise && lcnt != SAT)
        lcnt <= lcnt + 16'd1;

      // A line length is only trusted if it began at a real HSYNC edge
      // and the counter did not run away.
      if (hs_rise) begin
        line_ht  <= hcnt;
        ht_valid <= hs_seen & (hcnt != SAT);
        hs_seen  <= 1'b1;
      end

      if (vs_rise)
        w_lat <= 1'b0;
      else if (de_fall && !w_lat) begin
        w_ref <= wid;
        w_lat <= 1'b1;
      end
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else begin
      pix_valid <= s2_de;
      pix_data  <= s2_rgb;
      pix_x     <= x_cnt;
      pix_y     <= y_cnt;
      sof       <= s2_de & (x_cnt == '0) & (y_cnt == '0);
      eol       <= s2_de & ~s1_de;
    end
  end

  // Frame bookkeeping; the frame ending while in SEARCH is partial.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      meas_width  <= '0;
      meas_height <= '0;
      meas_htotal <= '0;
      meas_vtotal <= '0;
      frame_bad   <= 1'b0;
      prev_meas   <= '0;
      prev_ok     <= 1'b0;
    end else if (vs_rise) begin
      if (state != SEARCH)
        {meas_width, meas_height, meas_htotal, meas_vtotal} <= meas_cur;
      prev_meas <= meas_cur;
      prev_ok   <= (state != SEARCH) & ~bad_now;
      frame_bad <= 1'b0;
    end else begin
      frame_bad <= bad_now;
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state <= SEARCH;
      mcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      mcnt  <= mcnt_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    mcnt_n  = mcnt;
    err_n   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (vs_rise) begin
          state_n = TRACK;
          mcnt_n  = '0;
        end
      end
      TRACK: begin
        if (vs_rise) begin
          if (!match)
            mcnt_n = '0;
          else begin
            mcnt_n = mcnt + 4'd1;
            if (mcnt + 4'd1 >= LOCK_M1)
              state_n = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (hcnt == SAT) begin
          state_n = SEARCH;
          err_n   = 1'b1;
        end else if (vs_rise && !match) begin
          state_n = TRACK;
          mcnt_n  = '0;
          err_n   = 1'b1;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_comb begin
    locked  = (state == LOCKED);
    fmt_err = err_q;
  end

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Bench for lcd_rgb_rx: 16x8 active, htotal 20, vtotal 12 directed frames,
// pixel scoreboard plus lock/measurement checks on both sync polarities.
module tb_lcd_rgb_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       nRST, de, hs, vs;
  logic [4:0] r, b;
  logic [5:0] g;

  logic        a_pv, a_sof, a_eol, a_lk, a_fe;
  logic [15:0] a_pd, a_px, a_py, a_mw, a_mh, a_mht, a_mvt;
  logic        b_pv, b_sof, b_eol, b_lk, b_fe;
  logic [15:0] b_pd, b_px, b_py, b_mw, b_mh, b_mht, b_mvt;

  lcd_rgb_rx #(.SYNC_POL(1'b1), .LOCK_FRAMES(3)) dut_a (
    .PixelClk(clk), .nRST(nRST),
    .LCD_DE(de), .LCD_HSYNC(hs), .LCD_VSYNC(vs),
    .LCD_R(r), .LCD_G(g), .LCD_B(b),
    .pix_valid(a_pv), .pix_data(a_pd),
    .pix_x(a_px), .pix_y(a_py),
    .sof(a_sof), .eol(a_eol),
    .meas_width(a_mw), .meas_height(a_mh),
    .meas_htotal(a_mht), .meas_vtotal(a_mvt),
    .locked(a_lk), .fmt_err(a_fe)
  );

  lcd_rgb_rx #(.SYNC_POL(1'b0), .LOCK_FRAMES(3)) dut_b (
    .PixelClk(clk), .nRST(nRST),
    .LCD_DE(de), .LCD_HSYNC(~hs), .LCD_VSYNC(~vs),
    .LCD_R(r), .LCD_G(g), .LCD_B(b),
    .pix_valid(b_pv), .pix_data(b_pd),
    .pix_x(b_px), .pix_y(b_py),
    .sof(b_sof), .eol(b_eol),
    .meas_width(b_mw), .meas_height(b_mh),
    .meas_htotal(b_mht), .meas_vtotal(b_mvt),
    .locked(b_lk), .fmt_err(b_fe)
  );

  typedef struct {
    int          cyc;
    logic [15:0] d, x, y;
    logic        sof, eol;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   fe_a = 0;
  int   fe_b = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: pops one expected pixel per valid output.
  always @(negedge clk) begin
    if (nRST) begin
      if (a_pv) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_extra: got x=%0d y=%0d expected none",
                   a_px, a_py);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("pix_lat", 64'(cyc), 64'(e.cyc));
          chk("pix", {a_pd, a_px, a_py, a_sof, a_eol},
              {e.d, e.x, e.y, e.sof, e.eol});
        end
      end
      if (a_fe) fe_a++;
      if (b_fe) fe_b++;
    end
  end

  // One 12-line frame; line 'bad' (0-based active) is 15 px wide.
  // Lock is checked shortly after the frame's VSYNC leading edge.
  task automatic drive_frame(input int bad, input logic lk,
                             input int stop);
    int   w;
    logic act;
    exp_t e;
    for (int ln = 0; ln < 12; ln++) begin
      for (int c = 0; c < 20; c++) begin
        if (ln * 20 + c == stop) return;
        @(negedge clk);
        hs  = (c < 2);
        vs  = (ln < 2);
        w   = (ln - 2 == bad) ? 15 : 16;
        act = (ln >= 2) && (ln < 10) && (c >= 3) && (c < 3 + w);
        de  = act;
        if (act) begin
          e.x   = 16'(c - 3);
          e.y   = 16'(ln - 2);
          e.d   = 16'(e.y * 256 + e.x);
          e.cyc = cyc + 3;
          e.sof = (e.x == 0) && (e.y == 0);
          e.eol = (e.x == 16'(w - 1));
          {r, g, b} = e.d;
          sbq.push_back(e);
        end else begin
          {r, g, b} = 16'h0;
        end
        if (ln == 0 && c == 10) begin
          chk("lock_a", 64'(a_lk), 64'(lk));
          chk("lock_b", 64'(b_lk), 64'(lk));
        end
      end
    end
  endtask

  task automatic chk_meas(input int w, input int h, input int ht,
                          input int vt);
    chk("meas_a", {a_mw, a_mh, a_mht, a_mvt},
        {16'(w), 16'(h), 16'(ht), 16'(vt)});
    chk("meas_b", {b_mw, b_mh, b_mht, b_mvt},
        {16'(w), 16'(h), 16'(ht), 16'(vt)});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_a"}, {a_pv, a_pd, a_px, a_py, a_sof, a_eol, a_lk, a_fe},
        '0);
    chk({nm, "_b"}, {b_pv, b_pd, b_px, b_py, b_sof, b_eol, b_lk, b_fe},
        '0);
    chk_meas(0, 0, 0, 0);
  endtask

  task automatic idle();
    de = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    {r, g, b} = 16'h0;
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    chk_zero("rst");
    nRST = 1'b1;

    drive_frame(-1, 1'b0, -1);
    chk_meas(0, 0, 0, 0);
    drive_frame(-1, 1'b0, -1);
    chk_meas(16, 8, 20, 12);
    drive_frame(-1, 1'b0, -1);
    drive_frame(-1, 1'b1, -1);

    drive_frame(3, 1'b1, -1);
    drive_frame(-1, 1'b0, -1);
    chk("fe_a_w", 64'(fe_a), 64'd1);
    chk("fe_b_w", 64'(fe_b), 64'd1);
    drive_frame(-1, 1'b0, -1);
    drive_frame(-1, 1'b0, -1);
    drive_frame(-1, 1'b1, -1);

    @(negedge clk);
    idle();
    repeat (65540) @(negedge clk);
    chk("fe_a_s", 64'(fe_a), 64'd2);
    chk("fe_b_s", 64'(fe_b), 64'd2);
    chk("lock_stall", {a_lk, b_lk}, 2'b00);
    chk_meas(16, 8, 20, 12);

    drive_frame(-1, 1'b0, -1);
    drive_frame(-1, 1'b0, -1);
    drive_frame(-1, 1'b0, -1);
    drive_frame(-1, 1'b1, -1);
    chk_meas(16, 8, 20, 12);
    chk("fe_a_r", 64'(fe_a), 64'd2);

    drive_frame(-1, 1'b1, 68);
    #2 nRST = 1'b0;
    #1 chk_zero("midrst");
    sbq.delete();
    idle();
    repeat (3) @(negedge clk);
    nRST = 1'b1;

    drive_frame(-1, 1'b0, -1);
    chk_meas(0, 0, 0, 0);
    drive_frame(-1, 1'b0, -1);
    drive_frame(-1, 1'b0, -1);
    drive_frame(-1, 1'b1, -1);
    chk_meas(16, 8, 20, 12);

    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);
    chk("sb_drain", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
